i2c_codec_target: RTL and testbench
===================================

I2C_CODEC_TARGET -- requirements
Module: i2c_codec_target

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h1A, the 7-bit target address (write byte 0x34).
REQ-002 The block SHALL have parameter NUM_REGS, default 10, the number of implemented 9-bit registers.
REQ-003 Port clk, input, 1: the single clock; every flop SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port i2c_sclk, input, 1: the I2C clock from the bus master; asynchronous to clk.
REQ-006 Port i2c_sdin_in, input, 1: sampled level of the open-drain SDA pad.
REQ-007 Port i2c_sdin_oe, output, 1: 1 SHALL pull SDA low; 0 SHALL release it; SDA is never driven high.
REQ-008 Port rd_addr, input, 4: combinational register read index.
REQ-009 Port rd_data, output, 9: value of register rd_addr, or 0 when rd_addr >= NUM_REGS.
REQ-010 Ports wr_valid (output, 1), wr_addr (output, 7) and wr_data (output, 9): one-cycle commit strobe with its register address and data.
REQ-011 Port busy, output, 1: high from a detected START until a STOP or reset.

Function
REQ-012 i2c_sclk and i2c_sdin_in SHALL each pass through a 2-flop synchronizer, and all edge detection SHALL use the synchronized values; clk SHALL be at least 8x the SCL rate.
REQ-013 START (SDA falling while SCL is high) SHALL enter state ADDR from any state, which also covers a repeated START, and SHALL clear the bit counter.
REQ-014 STOP (SDA rising while SCL is high) SHALL enter IDLE from any state, release i2c_sdin_oe and drop busy; a partial transfer SHALL cause no write.
REQ-015 States SHALL be IDLE, ADDR, ACK0, BYTE1, ACK1, BYTE2, ACK2 and IGNORE, with data bits sampled on SCL rising edges, MSB first, 8 bits per byte.
REQ-016 In ADDR, after 8 bits:
- an address match with R/W=0 SHALL enter ACK0;
- a mismatch or R/W=1 SHALL enter IGNORE with no ACK.
REQ-017 In each ACK state, i2c_sdin_oe SHALL assert on the first SCL falling edge after the 8th bit and deassert on the next SCL falling edge.
REQ-018 After the ACK bit, ACK0 SHALL proceed to BYTE1 and ACK1 SHALL proceed to BYTE2.
REQ-019 The byte1/byte2 pair SHALL be decoded as {reg_addr[6:0], data[8:0]}.
REQ-020 When BYTE2 completes with reg_addr < NUM_REGS, the block SHALL, one clk after the detected 8th SCL rising edge:
- write the register;
- pulse wr_valid for exactly one cycle with wr_addr and wr_data;
- enter ACK2.
REQ-021 When BYTE2 completes with reg_addr == 7'h0F, all registers SHALL clear to 0, wr_valid SHALL pulse and the byte SHALL be ACKed.
REQ-022 Any other out-of-range reg_addr SHALL be NACKed with no write, no wr_valid, and entry to IGNORE.
REQ-023 After ACK2 the state SHALL become IGNORE, where further bytes are NACKed until a START or STOP.
REQ-024 A START or STOP during ACK drive SHALL release i2c_sdin_oe in the same cycle the condition is detected.
REQ-025 rd_data SHALL reflect a write on the cycle after the wr_valid pulse.

Reset
REQ-026 While rst is high, the following SHALL hold on the next clk edge:
- state = IDLE;
- i2c_sdin_oe = 0, wr_valid = 0, wr_addr = 0, wr_data = 0, busy = 0;
- all registers = 0;
- synchronizers reset to 1 (idle bus).
REQ-027 Reset mid-transfer SHALL abort with no write; after reset deasserts, the block SHALL ignore bus traffic until the next START.

Structure
REQ-028 A shared package SHALL hold:
- the state enum;
- DEV_ADDR default, RESET_REG = 7'h0F, REG_W = 9.
REQ-029 Synchronization plus START/STOP/SCL-edge detection SHALL be one sub-module, i2c_bus_sync; the FSM and the register file SHALL reside in i2c_codec_target.

Verification
REQ-030 Bytes 0x34, 0x04, 0x7F then STOP -> three ACKs, one wr_valid (wr_addr=2, wr_data=0x07F), rd_addr=2 returns 0x07F.
REQ-031 Address byte 0x36, or 0x35 (R/W=1) -> SDA never pulled low, no wr_valid, registers unchanged.
REQ-032 Bytes 0x34, 0x14, 0x00 (reg 10) -> ACKs on bytes 1-2, NACK on byte 3, no write.
REQ-033 Registers preloaded nonzero, then bytes 0x34, 0x1E, 0x00 -> all rd_data = 0, wr_valid pulses once.
REQ-034 STOP after 4 bits of byte1 -> IDLE, busy=0, no write; a following full 0x34, 0x00, 0x17 transfer writes reg0=0x017.
REQ-035 rst asserted while i2c_sdin_oe=1 during ACK0 -> i2c_sdin_oe=0 on the next clk, the remaining bytes are ignored, and the next transfer succeeds.

Source files
------------

// File: rtl/i2c_codec_target_pkg.sv
// Shared definitions for the I2C codec control target.
package i2c_codec_target_pkg;

   localparam logic [6:0]  DEV_ADDR_DEFAULT = 7'h1A;
   localparam logic [6:0]  RESET_REG        = 7'h0F;
   localparam int unsigned REG_W            = 9;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACK0,
      BYTE1,
      ACK1,
      BYTE2,
      ACK2,
      IGNORE
   } state_t;

endpackage

// File: rtl/i2c_codec_target_if.sv
// I2C pin bundle: the bus master drives SCL and the sampled SDA level.
// The target only ever pulls SDA low through the open-drain enable.
interface i2c_codec_target_if;
   logic i2c_sclk;
   logic i2c_sdin_in;
   logic i2c_sdin_oe;

   modport master (output i2c_sclk, output i2c_sdin_in, input i2c_sdin_oe);
   modport slave  (input i2c_sclk, input i2c_sdin_in, output i2c_sdin_oe);
endinterface

// File: rtl/i2c_codec_target_bus_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL edges and START/STOP.
// Every flop resets to 1 so the bus looks idle coming out of reset.
module i2c_bus_sync (
   input  logic clk,
   input  logic rst,
   input  logic sclk_async,
   input  logic sda_async,
   output logic sda_lvl,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   // [0],[1] form the 2-flop synchronizer; [2] holds the previous synced value
   logic [2:0] scl_sr;
   logic [2:0] sda_sr;

   // synchronizer and history shift registers
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sr <= '1;
         sda_sr <= '1;
      end else begin
         scl_sr <= {scl_sr[1:0], sclk_async};
         sda_sr <= {sda_sr[1:0], sda_async};
      end
   end

   assign sda_lvl   = sda_sr[1];
   assign scl_rise  =  scl_sr[1] & ~scl_sr[2];
   assign scl_fall  = ~scl_sr[1] &  scl_sr[2];
   assign start_det =  scl_sr[1] &  scl_sr[2] &  sda_sr[2] & ~sda_sr[1];
   assign stop_det  =  scl_sr[1] &  scl_sr[2] & ~sda_sr[2] &  sda_sr[1];

endmodule

// File: rtl/i2c_codec_target.sv
// Write-only I2C codec control target: address byte, then a 16-bit word
// {reg_addr[6:0], data[8:0]} committed into a small 9-bit register file.
module i2c_codec_target
   import i2c_codec_target_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
   parameter int unsigned NUM_REGS = 10
) (
   input  logic             clk,
   input  logic             rst,
   i2c_codec_target_if.slave bus,
   input  logic [3:0]       rd_addr,
   output logic [REG_W-1:0] rd_data,
   output logic             wr_valid,
   output logic [6:0]       wr_addr,
   output logic [REG_W-1:0] wr_data,
   output logic             busy
);

   logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

   i2c_bus_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .sclk_async (bus.i2c_sclk),
      .sda_async  (bus.i2c_sdin_in),
      .sda_lvl    (sda_lvl),
      .scl_rise   (scl_rise),
      .scl_fall   (scl_fall),
      .start_det  (start_det),
      .stop_det   (stop_det)
   );

   state_t           state, state_nxt;
   logic [2:0]       bit_cnt, bit_cnt_nxt;
   logic [6:0]       shreg, shreg_nxt;
   logic [7:0]       byte1, byte1_nxt;
   logic             oe, oe_nxt;
   logic             busy_nxt;
   logic             do_write, do_clear;
   logic [7:0]       shifted;
   logic [6:0]       reg_addr;
   logic [REG_W-1:0] reg_data;
   logic             reg_in_range;
   logic [REG_W-1:0] regs [NUM_REGS];

   assign shifted      = {shreg, sda_lvl};
   assign reg_addr     = byte1[7:1];
   assign reg_data     = {byte1[0], shifted};
   assign reg_in_range = 32'(reg_addr) < NUM_REGS;

   assign bus.i2c_sdin_oe = oe;

   // FSM and transfer state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         byte1    <= '0;
         oe       <= 1'b0;
         busy     <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_cnt_nxt;
         shreg    <= shreg_nxt;
         byte1    <= byte1_nxt;
         oe       <= oe_nxt;
         busy     <= busy_nxt;
         wr_valid <= do_write | do_clear;
         if (do_write || do_clear) begin
            wr_addr <= reg_addr;
            wr_data <= reg_data;
         end
      end
   end

   // next-state logic; STOP and START override every state
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      byte1_nxt   = byte1;
      oe_nxt      = oe;
      busy_nxt    = busy;
      do_write    = 1'b0;
      do_clear    = 1'b0;

      if (stop_det) begin
         state_nxt = IDLE;
         oe_nxt    = 1'b0;
         busy_nxt  = 1'b0;
      end else if (start_det) begin
         state_nxt   = ADDR;
         bit_cnt_nxt = '0;
         oe_nxt      = 1'b0;
         busy_nxt    = 1'b1;
      end else begin
         case (state)
            ADDR, BYTE1, BYTE2: begin
               if (scl_rise) begin
                  shreg_nxt   = shifted[6:0];
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (state == ADDR) begin
                        state_nxt = (shifted == {DEV_ADDR, 1'b0}) ? ACK0 : IGNORE;
                     end else if (state == BYTE1) begin
                        byte1_nxt = shifted;
                        state_nxt = ACK1;
                     end else if (reg_in_range) begin
                        do_write  = 1'b1;
                        state_nxt = ACK2;
                     end else if (reg_addr == RESET_REG) begin
                        do_clear  = 1'b1;
                        state_nxt = ACK2;
                     end else begin
                        state_nxt = IGNORE;
                     end
                  end
               end
            end
            ACK0, ACK1, ACK2: begin
               // oe doubles as the ACK phase: first fall drives, second releases
               if (scl_fall) begin
                  if (!oe) begin
                     oe_nxt = 1'b1;
                  end else begin
                     oe_nxt = 1'b0;
                     if (state == ACK0)      state_nxt = BYTE1;
                     else if (state == ACK1) state_nxt = BYTE2;
                     else                    state_nxt = IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // register file: single write or global clear
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (rst || do_clear) regs[i] <= '0;
         else if (do_write && reg_addr == 7'(i)) regs[i] <= reg_data;
      end
   end

   // combinational read port, zero outside the implemented range
   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (rd_addr == 4'(i)) rd_data = regs[i];
      end
   end

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench for i2c_codec_target: bit-banged I2C master, transaction-level model.
module tb_i2c_codec_target;
   import i2c_codec_target_pkg::*;

   localparam int Q      = 80;  // quarter SCL period (8 clk cycles)
   localparam int N_REGS = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic [3:0] rd_addr = '0;
   logic [8:0] rd_data;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [8:0] wr_data;
   logic       busy;

   always #5 clk = ~clk;

   i2c_codec_target_if bus ();
   assign bus.i2c_sclk    = scl_m;
   assign bus.i2c_sdin_in = sda_m & ~bus.i2c_sdin_oe;

   i2c_codec_target #(.DEV_ADDR(7'h1A), .NUM_REGS(N_REGS)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   int         wr_total = 0;
   logic [6:0] wr_addr_seen = '0;
   logic [8:0] wr_data_seen = '0;
   logic [8:0] mdl [16];
   logic [7:0] txq [$];

   always @(negedge clk) begin
      if (wr_valid === 1'b1) begin
         wr_total++;
         wr_addr_seen = wr_addr;
         wr_data_seen = wr_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_regs();
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         check($sformatf("rd%0d", i), 32'(rd_data), 32'((i < N_REGS) ? mdl[i] : 9'd0));
      end
   endtask

   task automatic bus_start();
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b0; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b1; #Q;
   endtask

   task automatic bus_bit(input logic b);
      sda_m = b;    #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
   endtask

   task automatic bus_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) bus_bit(b[i]);
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      ack = ~bus.i2c_sdin_in;
      #Q;
      scl_m = 1'b0; #Q;
      check("ack_release", 32'(bus.i2c_sdin_oe), 32'd0);
   endtask

   // Plays txq as one transfer and predicts ACKs and the commit from the byte rules.
   task automatic run_xfer(input bit do_stop);
      logic       ack, e, addr_ok, exp_wr;
      logic [6:0] ra, exp_wa;
      logic [8:0] d, exp_wd;
      int         wr_before;
      @(negedge clk);
      wr_before = wr_total;
      addr_ok = 1'b0; exp_wr = 1'b0; exp_wa = '0; exp_wd = '0;
      bus_start();
      check("busy_start", 32'(busy), 32'd1);
      for (int k = 0; k < txq.size(); k++) begin
         bus_byte(txq[k], ack);
         e = 1'b0;
         if (k == 0) begin
            addr_ok = (txq[0] == {DEV_ADDR_DEFAULT, 1'b0});
            e = addr_ok;
         end else if (k == 1) begin
            e = addr_ok;
         end else if (k == 2 && addr_ok) begin
            ra = txq[1][7:1];
            d  = {txq[1][0], txq[2]};
            if (ra < 7'(N_REGS)) begin
               e = 1'b1; exp_wr = 1'b1; exp_wa = ra; exp_wd = d;
               mdl[ra[3:0]] = d;
            end else if (ra == RESET_REG) begin
               e = 1'b1; exp_wr = 1'b1; exp_wa = ra; exp_wd = d;
               foreach (mdl[i]) mdl[i] = '0;
            end
         end
         check($sformatf("ack_byte%0d", k), 32'(ack), 32'(e));
      end
      if (do_stop) begin
         bus_stop();
         repeat (10) @(negedge clk);
         check("busy_stop", 32'(busy), 32'd0);
      end
      check("wr_count", 32'(wr_total - wr_before), 32'(exp_wr));
      if (exp_wr) begin
         check("wr_addr", 32'(wr_addr_seen), 32'(exp_wa));
         check("wr_data", 32'(wr_data_seen), 32'(exp_wd));
      end
      check_regs();
   endtask

   task automatic xfer3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      txq = {};
      txq.push_back(b0); txq.push_back(b1); txq.push_back(b2);
      run_xfer(1'b1);
   endtask

   initial begin
      logic       ack;
      logic [6:0] ra_r;
      logic [7:0] b;
      int         wr_before, n;

      foreach (mdl[i]) mdl[i] = '0;

      // reset state
      repeat (4) @(negedge clk);
      check("rst_oe", 32'(bus.i2c_sdin_oe), 32'd0);
      check("rst_wr_valid", 32'(wr_valid), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_regs();

      // basic write, reg 2 = 0x07F
      xfer3(8'h34, 8'h04, 8'h7F);
      // wrong address and read direction
      xfer3(8'h36, 8'h04, 8'h11);
      xfer3(8'h35, 8'h06, 8'h22);
      // reg 10 out of range
      xfer3(8'h34, 8'h14, 8'h00);

      // preload then global clear
      xfer3(8'h34, 8'h02, 8'hA5);
      xfer3(8'h34, 8'h0B, 8'h3C);
      xfer3(8'h34, 8'h13, 8'hFF);
      xfer3(8'h34, 8'h1E, 8'h00);

      // STOP after 4 bits of the first data byte
      @(negedge clk);
      wr_before = wr_total;
      bus_start();
      bus_byte(8'h34, ack);
      check("part_ack0", 32'(ack), 32'd1);
      for (int i = 0; i < 4; i++) bus_bit(1'b1);
      bus_stop();
      repeat (10) @(negedge clk);
      check("part_busy", 32'(busy), 32'd0);
      check("part_wr_count", 32'(wr_total - wr_before), 32'd0);
      xfer3(8'h34, 8'h00, 8'h17);

      // repeated START after a half-finished word
      txq = {};
      txq.push_back(8'h34); txq.push_back(8'h04);
      run_xfer(1'b0);
      xfer3(8'h34, 8'h06, 8'h55);

      // reset while ACK0 is driving SDA low
      @(negedge clk);
      wr_before = wr_total;
      bus_start();
      b = 8'h34;
      for (int i = 7; i >= 0; i--) bus_bit(b[i]);
      sda_m = 1'b1; #Q;
      check("ack0_drive", 32'(bus.i2c_sdin_oe), 32'd1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      check("rst_release_oe", 32'(bus.i2c_sdin_oe), 32'd0);
      check("rst_busy_mid", 32'(busy), 32'd0);
      rst = 1'b0;
      foreach (mdl[i]) mdl[i] = '0;
      #(Q - 20);
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
      bus_byte(8'h04, ack);
      check("post_rst_ack1", 32'(ack), 32'd0);
      bus_byte(8'h7F, ack);
      check("post_rst_ack2", 32'(ack), 32'd0);
      bus_stop();
      repeat (10) @(negedge clk);
      check("post_rst_wr_count", 32'(wr_total - wr_before), 32'd0);
      check_regs();
      xfer3(8'h34, 8'h04, 8'h7F);

      // randomized transfers
      for (int t = 0; t < 24; t++) begin
         txq = {};
         b = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom_range(0, 255));
         txq.push_back(b);
         if ($urandom_range(0, 4) == 0) begin
            b = 8'($urandom_range(0, 255));
         end else begin
            ra_r = 7'($urandom_range(0, N_REGS - 1));
            b = {ra_r, 1'($urandom_range(0, 1))};
         end
         txq.push_back(b);
         n = ($urandom_range(0, 5) == 0) ? 2 : 1;
         for (int i = 0; i < n; i++) txq.push_back(8'($urandom_range(0, 255)));
         run_xfer(1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
